// File: rtl/mem_ctrl_if.sv
// Request/response bundle between the MAR/MDR datapath and mem_ctrl.
//   mem_read / mem_write : request strobes, sampled only while the controller is idle
//   address / wdata      : word address from MAR Q, write data from MDR Q
//   Mdatain              : read data toward MDR Mdatain (registered)
//   mdr_load             : one-cycle MDR read+enable strobe on read completion
//   busy / done          : access in flight / one-cycle completion pulse
//   addr_err             : qualifies done when the access was out of range
interface mem_ctrl_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] Mdatain;
  logic        mdr_load;
  logic        busy;
  logic        done;
  logic        addr_err;

  modport master (
    output mem_read, mem_write, address, wdata,
    input  Mdatain, mdr_load, busy, done, addr_err
  );

  modport slave (
    input  mem_read, mem_write, address, wdata,
    output Mdatain, mdr_load, busy, done, addr_err
  );
endinterface

// File: rtl/mem_ctrl.sv
// Word-addressed RAM with a fixed number of wait states, feeding the MDR.
// Ports:
//   clk  : rising-edge clock
//   clr  : synchronous active-high reset (RAM contents untouched)
//   bus  : mem_ctrl_if slave side (request in, read data / strobes out)
// A request sampled in IDLE is latched, waits WAIT_STATES cycles in ACCESS,
// performs the RAM operation on the last ACCESS edge and reports in DONE.
module mem_ctrl #(
  parameter int DEPTH       = 512,
  parameter int ADDR_BITS   = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic       clk,
  input  logic       clr,
  mem_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic [31:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        is_rd_q, is_rd_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic                 mem_we;
  logic                 oor;
  logic [ADDR_BITS-1:0] idx;

  assign idx = addr_q[ADDR_BITS-1:0];
  assign oor = |addr_q[31:ADDR_BITS];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    is_rd_d = is_rd_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          addr_d  = bus.address;
          wdata_d = bus.wdata;
          // Read has priority when both strobes are raised together.
          is_rd_d = bus.mem_read;
          cnt_d   = WS;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = DONE;
          err_d   = oor;
          if (is_rd_q) rdata_d = oor ? 32'd0 : mem[idx];
          else         mem_we  = !oor;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      is_rd_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_rd_q <= is_rd_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM is not reset; clr on the completing edge must still cancel the write.
  always_ff @(posedge clk) begin
    if (mem_we && !clr) mem[idx] <= wdata_q;
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.mdr_load = (state_q == DONE) && is_rd_q;
  assign bus.addr_err = (state_q == DONE) && err_q;
  assign bus.Mdatain  = rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  mem_ctrl_if bus_a();
  mem_ctrl_if bus_b();

  mem_ctrl #(.DEPTH(512), .ADDR_BITS(9), .WAIT_STATES(2)) dut_a (
    .clk(clk), .clr(clr), .bus(bus_a)
  );
  mem_ctrl #(.DEPTH(512), .ADDR_BITS(9), .WAIT_STATES(0)) dut_b (
    .clk(clk), .clr(clr), .bus(bus_b)
  );

  // MDR model: captures Mdatain whenever the load strobe is high at an edge.
  logic [31:0] mdr_q;
  always @(posedge clk) begin
    if (clr) mdr_q <= 32'd0;
    else if (bus_a.mdr_load) mdr_q <= bus_a.Mdatain;
  end

  int total = 0;
  int bad   = 0;

  logic        obs_busy [16];
  logic        obs_done [16];
  logic        obs_load [16];
  logic        obs_err  [16];
  logic [31:0] obs_data [16];

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      bus_a.mem_read = rd; bus_a.mem_write = wr; bus_a.address = a; bus_a.wdata = d;
    end else begin
      bus_b.mem_read = rd; bus_b.mem_write = wr; bus_b.address = a; bus_b.wdata = d;
    end
  endtask

  // Presents a request so it is sampled at the next edge; afterwards the
  // address/data lines are scrambled unless the request is held.
  task automatic issue(input int sel, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d, input bit hold);
    @(posedge clk); #1;
    drive(sel, rd, wr, a, d);
    @(posedge clk); #1;
    if (!hold) drive(sel, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0BAD_0BAD);
  endtask

  // Records outputs mid-cycle for n consecutive cycles.
  task automatic capture(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sel == 0) begin
        obs_busy[i] = bus_a.busy; obs_done[i] = bus_a.done; obs_load[i] = bus_a.mdr_load;
        obs_err[i]  = bus_a.addr_err; obs_data[i] = bus_a.Mdatain;
      end else begin
        obs_busy[i] = bus_b.busy; obs_done[i] = bus_b.done; obs_load[i] = bus_b.mdr_load;
        obs_err[i]  = bus_b.addr_err; obs_data[i] = bus_b.Mdatain;
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", bus_a.busy); end
    total++; if (bus_a.done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", bus_a.done); end
    total++; if (bus_a.mdr_load !== 1'b0) begin bad++; $display("FAIL reset_load got %b want 0", bus_a.mdr_load); end
    total++; if (bus_a.addr_err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", bus_a.addr_err); end
    total++; if (bus_a.Mdatain !== 32'd0) begin bad++; $display("FAIL reset_data got %h want 0", bus_a.Mdatain); end
    total++; if (bus_b.busy !== 1'b0) begin bad++; $display("FAIL reset_busy_b got %b want 0", bus_b.busy); end
  endtask

  task automatic test_write();
    issue(0, 1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0);
    capture(0, 6);
    for (int i = 0; i < 6; i++) begin
      total++; if (obs_busy[i] !== (i < 4)) begin bad++; $display("FAIL write_busy[%0d] got %b want %b", i, obs_busy[i], (i < 4)); end
      total++; if (obs_done[i] !== (i == 3)) begin bad++; $display("FAIL write_done[%0d] got %b want %b", i, obs_done[i], (i == 3)); end
      total++; if (obs_load[i] !== 1'b0) begin bad++; $display("FAIL write_load[%0d] got %b want 0", i, obs_load[i]); end
    end
    total++; if (obs_data[5] !== 32'd0) begin bad++; $display("FAIL write_data got %h want 0", obs_data[5]); end
  endtask

  task automatic test_read();
    issue(0, 1'b1, 1'b0, 32'd5, 32'd0, 1'b0);
    capture(0, 6);
    for (int i = 0; i < 6; i++) begin
      total++; if (obs_done[i] !== (i == 3)) begin bad++; $display("FAIL read_done[%0d] got %b want %b", i, obs_done[i], (i == 3)); end
      total++; if (obs_load[i] !== (i == 3)) begin bad++; $display("FAIL read_load[%0d] got %b want %b", i, obs_load[i], (i == 3)); end
    end
    total++; if (obs_data[3] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL read_data got %h want deadbeef", obs_data[3]); end
    total++; if (mdr_q !== 32'hDEAD_BEEF) begin bad++; $display("FAIL read_mdr got %h want deadbeef", mdr_q); end
  endtask

  task automatic test_out_of_range();
    issue(0, 1'b0, 1'b1, 32'd0, 32'hCAFE_0000, 1'b0);
    capture(0, 6);
    issue(0, 1'b0, 1'b1, 32'h0000_0200, 32'h11, 1'b0);
    capture(0, 6);
    for (int i = 0; i < 6; i++) begin
      total++; if (obs_err[i] !== (i == 3)) begin bad++; $display("FAIL oor_wr_err[%0d] got %b want %b", i, obs_err[i], (i == 3)); end
    end
    issue(0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0);
    capture(0, 6);
    total++; if (obs_data[3] !== 32'hCAFE_0000) begin bad++; $display("FAIL oor_ram0 got %h want cafe0000", obs_data[3]); end
    issue(0, 1'b1, 1'b0, 32'h0000_0200, 32'd0, 1'b0);
    capture(0, 6);
    total++; if (obs_data[3] !== 32'd0) begin bad++; $display("FAIL oor_rd_data got %h want 0", obs_data[3]); end
    total++; if (obs_err[3] !== 1'b1) begin bad++; $display("FAIL oor_rd_err got %b want 1", obs_err[3]); end
    total++; if (obs_done[3] !== 1'b1) begin bad++; $display("FAIL oor_rd_done got %b want 1", obs_done[3]); end
    total++; if (obs_err[4] !== 1'b0) begin bad++; $display("FAIL oor_err_clear got %b want 0", obs_err[4]); end
  endtask

  task automatic test_both();
    issue(0, 1'b0, 1'b1, 32'd7, 32'h1234, 1'b0);
    capture(0, 6);
    issue(0, 1'b1, 1'b1, 32'd7, 32'h5555, 1'b0);
    capture(0, 6);
    total++; if (obs_data[3] !== 32'h1234) begin bad++; $display("FAIL both_data got %h want 1234", obs_data[3]); end
    total++; if (obs_load[3] !== 1'b1) begin bad++; $display("FAIL both_load got %b want 1", obs_load[3]); end
    total++; if (obs_err[3] !== 1'b0) begin bad++; $display("FAIL both_err got %b want 0", obs_err[3]); end
    issue(0, 1'b1, 1'b0, 32'd7, 32'd0, 1'b0);
    capture(0, 6);
    total++; if (obs_data[3] !== 32'h1234) begin bad++; $display("FAIL both_ram7 got %h want 1234", obs_data[3]); end
  endtask

  task automatic test_abort();
    issue(0, 1'b0, 1'b1, 32'd9, 32'h9999, 1'b0);
    capture(0, 6);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b1, 32'd9, 32'hAAAA);
    @(posedge clk); #1;                        // write accepted, first ACCESS cycle
    drive(0, 1'b1, 1'b0, 32'd5, 32'd0);        // request while busy
    @(posedge clk); #1;                        // second ACCESS cycle
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    capture(0, 8);
    for (int i = 0; i < 8; i++) begin
      total++; if (obs_done[i] !== 1'b0) begin bad++; $display("FAIL abort_done[%0d] got %b want 0", i, obs_done[i]); end
      total++; if (obs_busy[i] !== 1'b0) begin bad++; $display("FAIL abort_busy[%0d] got %b want 0", i, obs_busy[i]); end
    end
    total++; if (obs_data[0] !== 32'd0) begin bad++; $display("FAIL abort_data got %h want 0", obs_data[0]); end
    total++; if (obs_load[0] !== 1'b0 || obs_err[0] !== 1'b0) begin bad++; $display("FAIL abort_strobes got %b%b want 00", obs_load[0], obs_err[0]); end
    issue(0, 1'b1, 1'b0, 32'd9, 32'd0, 1'b0);
    capture(0, 6);
    total++; if (obs_data[3] !== 32'h9999) begin bad++; $display("FAIL abort_ram9 got %h want 9999", obs_data[3]); end
  endtask

  task automatic test_ignore_busy();
    int ndone;
    issue(0, 1'b0, 1'b1, 32'd11, 32'hBBBB, 1'b0);
    @(posedge clk); #1;                        // ACCESS, counter was 1 at this edge
    drive(0, 1'b0, 1'b1, 32'd11, 32'hCCCC);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    capture(0, 6);
    ndone = 0;
    for (int i = 0; i < 6; i++) if (obs_done[i] === 1'b1) ndone++;
    total++; if (ndone !== 1) begin bad++; $display("FAIL busy_ndone got %0d want 1", ndone); end
    total++; if (obs_done[1] !== 1'b1) begin bad++; $display("FAIL busy_done_pos got %b want 1", obs_done[1]); end
    issue(0, 1'b1, 1'b0, 32'd11, 32'd0, 1'b0);
    capture(0, 6);
    total++; if (obs_data[3] !== 32'hBBBB) begin bad++; $display("FAIL busy_ram11 got %h want bbbb", obs_data[3]); end
  endtask

  task automatic test_wait0();
    issue(1, 1'b0, 1'b1, 32'd3, 32'h0303, 1'b0);
    capture(1, 4);
    total++; if (obs_done[1] !== 1'b1 || obs_done[0] !== 1'b0) begin bad++; $display("FAIL w0_wr_done got %b%b want 01", obs_done[0], obs_done[1]); end
    issue(1, 1'b1, 1'b0, 32'd3, 32'd0, 1'b1);
    capture(1, 9);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 9; i++) begin
      total++; if (obs_busy[i] !== (i % 3 != 2)) begin bad++; $display("FAIL w0_busy[%0d] got %b want %b", i, obs_busy[i], (i % 3 != 2)); end
      total++; if (obs_done[i] !== (i % 3 == 1)) begin bad++; $display("FAIL w0_done[%0d] got %b want %b", i, obs_done[i], (i % 3 == 1)); end
      total++; if (obs_load[i] !== (i % 3 == 1)) begin bad++; $display("FAIL w0_load[%0d] got %b want %b", i, obs_load[i], (i % 3 == 1)); end
    end
    total++; if (obs_data[1] !== 32'h0303) begin bad++; $display("FAIL w0_data got %h want 0303", obs_data[1]); end
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    test_reset();
    test_write();
    test_read();
    test_out_of_range();
    test_both();
    test_abort();
    test_ignore_busy();
    test_wait0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Word-addressed memory subsystem that sits directly upstream of the MDR in the single-bus datapath.
- Accepts read/write requests addressed by MAR, with write data from the MDR's Q output.
- Models a RAM with a configurable number of wait states.
- Drives the MDR's Mdatain input and issues a one-cycle load strobe (MDR read + enable) when read data is valid.

Parameters:
- DEPTH, 512, number of 32-bit words in the internal RAM array.
- ADDR_BITS, 9, index width; DEPTH == 2**ADDR_BITS.
- WAIT_STATES, 2, extra access cycles before a request completes; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  reset; synchronous, active-high.
- mem_read  input  1  read request, sampled only in IDLE.
- mem_write  input  1  write request, sampled only in IDLE.
- address  input  32  word address from MAR Q.
- wdata  input  32  write data from MDR Q.
- Mdatain  output  32  read data to MDR Mdatain; registered, holds last read value.
- mdr_load  output  1  one-cycle pulse on read completion; drives MDR read and enable.
- busy  output  1  high while a request is in progress (ACCESS or DONE).
- done  output  1  one-cycle pulse on completion of any request.
- addr_err  output  1  one-cycle pulse with done when the access was out of range.

Behaviour:
- Reset (clr high at an edge):
  - state=IDLE, counter=0, Mdatain=0, mdr_load=0, busy=0, done=0, addr_err=0.
  - RAM contents are not altered.
  - clr mid-access aborts the request: no RAM write occurs and no done pulse follows.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If mem_read or mem_write is high at an edge:
    - latch address, wdata and op;
    - counter=WAIT_STATES;
    - go to ACCESS.
  - If both are high, the read wins and the write is dropped. No error is flagged.
- ACCESS:
  - counter != 0: decrement and stay.
  - counter == 0: perform the operation and go to DONE.
  - Write: RAM[addr[ADDR_BITS-1:0]] <= latched wdata.
  - Read: Mdatain <= RAM[addr[ADDR_BITS-1:0]].
- Out of range (latched address[31:ADDR_BITS] != 0):
  - write is suppressed;
  - read loads Mdatain=0;
  - addr_err=1 in DONE.
- DONE:
  - done=1 for exactly one cycle.
  - mdr_load=1 for that cycle on reads only.
  - Return to IDLE on the next edge.
- busy:
  - 1 in ACCESS and DONE, 0 in IDLE.
  - Requests presented while busy are ignored, not queued.
  - A request held high through DONE is re-sampled in IDLE and starts a new access.
- Latency:
  - Request sampled at edge n gives done high during the cycle after edge n+WAIT_STATES+1.
  - That is WAIT_STATES+2 cycles from request to done.
  - Back-to-back throughput is one request per WAIT_STATES+3 cycles.
- Mdatain:
  - Changes only on read completion or clr.
  - Stable whenever mdr_load is high, so the MDR captures it at the edge ending the DONE cycle.
- Latched address and wdata:
  - Changes to address or wdata after sampling have no effect on the in-flight request.

Test Plan:
- clr, then write 0xDEADBEEF at address 5 with WAIT_STATES=2 -> busy high 4 cycles; done pulses once, 4 cycles after the request; mdr_load stays 0.
- Read address 5 -> Mdatain=0xDEADBEEF; mdr_load and done pulse together, 4 cycles after the request; the MDR captures 0xDEADBEEF.
- Read from address 0x00000200 (out of range) -> Mdatain=0, addr_err=1 and done=1 same cycle; a prior write of 0x11 to 0x200 leaves RAM[0] unchanged.
- mem_read and mem_write both high, address 7 holding 0x1234 -> read performed, Mdatain=0x1234, RAM[7] still 0x1234.
- Write request to address 9 (data 0xAAAA), then clr asserted in the second ACCESS cycle -> no done pulse, all outputs 0, a later read of 9 returns the old value; a second request raised while busy is ignored.
- WAIT_STATES=0 build: read request -> done 2 cycles later; held request repeats every 3 cycles.
